// File: rtl/layout_xform_sequencer.sv
// layout_xform_sequencer: queued swap/rotate command sequencer over an N x N layout register

// layout_swap_v: mirror rows, row r goes to row H-1-r
module layout_swap_v #(
  parameter int W = 6,
  parameter int H = 6,
  parameter int S = 1
) (
  input  logic [W*H*S-1:0] src,
  output logic [W*H*S-1:0] dst
);
  for (genvar r = 0; r < H; r++) begin : g_r
    for (genvar c = 0; c < W; c++) begin : g_c
      assign dst[((H-1-r)*W+c)*S +: S] = src[(r*W+c)*S +: S];
    end
  end
endmodule

// layout_swap_h: mirror columns, column c goes to column W-1-c
module layout_swap_h #(
  parameter int W = 6,
  parameter int H = 6,
  parameter int S = 1
) (
  input  logic [W*H*S-1:0] src,
  output logic [W*H*S-1:0] dst
);
  for (genvar r = 0; r < H; r++) begin : g_r
    for (genvar c = 0; c < W; c++) begin : g_c
      assign dst[(r*W+W-1-c)*S +: S] = src[(r*W+c)*S +: S];
    end
  end
endmodule

// layout_rot_l: dst(W-1-c, r) = src(r, c); result has W rows of H cells
module layout_rot_l #(
  parameter int W = 6,
  parameter int H = 6,
  parameter int S = 1
) (
  input  logic [W*H*S-1:0] src,
  output logic [W*H*S-1:0] dst
);
  for (genvar r = 0; r < H; r++) begin : g_r
    for (genvar c = 0; c < W; c++) begin : g_c
      assign dst[((W-1-c)*H+r)*S +: S] = src[(r*W+c)*S +: S];
    end
  end
endmodule

// layout_rot_r: dst(c, H-1-r) = src(r, c); result has W rows of H cells
module layout_rot_r #(
  parameter int W = 6,
  parameter int H = 6,
  parameter int S = 1
) (
  input  logic [W*H*S-1:0] src,
  output logic [W*H*S-1:0] dst
);
  for (genvar r = 0; r < H; r++) begin : g_r
    for (genvar c = 0; c < W; c++) begin : g_c
      assign dst[(c*H+H-1-r)*S +: S] = src[(r*W+c)*S +: S];
    end
  end
endmodule

// layout_xform_sequencer: loads a layout, applies queued commands one step per clock, hands off result
module layout_xform_sequencer #(
  parameter int N = 6,
  parameter int S = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N*N*S-1:0] load_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*S-1:0] out_data,
  output logic             busy
);
  localparam int L = N*N*S;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [4:0] head;
  logic [1:0] rep_q;
  logic [L-1:0] layout_q, sv, sh, rl, rr, xf;
  logic full, empty, push, apply, pop;
  layout_swap_v #(.W(N), .H(N), .S(S)) u_sv (.src(layout_q), .dst(sv));
  layout_swap_h #(.W(N), .H(N), .S(S)) u_sh (.src(layout_q), .dst(sh));
  layout_rot_l  #(.W(N), .H(N), .S(S)) u_rl (.src(layout_q), .dst(rl));
  layout_rot_r  #(.W(N), .H(N), .S(S)) u_rr (.src(layout_q), .dst(rr));
  assign xf = head[1:0] == 2'd0 ? sv : head[1:0] == 2'd1 ? sh : head[1:0] == 2'd2 ? rl : rr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = fifo_mem[rd_ptr[AW-1:0]];
  assign cmd_ready = !full;
  assign push = cmd_valid && !full && !abort;
  assign apply = state_q == RUN && !empty && !abort;
  assign pop = apply && rep_q == head[3:2];
  assign out_data = layout_q;
  // command storage; contents need no reset since occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= cmd_data;
  end
  // fifo pointers; abort flushes the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // layout register and repeat counter; abort keeps the layout but clears the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layout_q <= '0;
      rep_q <= '0;
    end else if (abort) begin
      rep_q <= '0;
    end else if (state_q == IDLE && load_valid) begin
      layout_q <= load_data;
      rep_q <= '0;
    end else if (apply) begin
      layout_q <= xf;
      rep_q <= pop ? 2'd0 : rep_q + 2'd1;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state and handshake outputs; abort overrides every transition
  always_comb begin
    state_d = state_q;
    load_ready = state_q == IDLE;
    busy = state_q == RUN;
    out_valid = state_q == DONE;
    if (abort) state_d = IDLE;
    else if (state_q == IDLE && load_valid) state_d = RUN;
    else if (pop && head[4]) state_d = DONE;
    else if (state_q == DONE && out_ready) state_d = IDLE;
  end
endmodule
